// File: rtl/rr_onehot_arbiter_if.sv
// rtl/rr_onehot_arbiter_if.sv - request/grant bundle shared by requesters and the round-robin arbiter
interface rr_onehot_arbiter_if #(
  parameter int N    = 16,
  parameter int IDXW = 4
);
  logic [N-1:0]    req;
  logic            done;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    grant_onehot;
  logic            timeout;

  // Requester side: raises requests and signals completion, observes the grant.
  modport master (
    output req,
    output done,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot,
    input  timeout
  );

  // Arbiter side: samples requests, owns the grant outputs.
  modport slave (
    input  req,
    input  done,
    output grant_valid,
    output grant_idx,
    output grant_onehot,
    output timeout
  );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// rtl/rr_onehot_arbiter.sv - round-robin arbiter with registered binary and one-hot grant plus hold limit
module rr_onehot_arbiter #(
  parameter int N        = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_onehot_arbiter_if.slave arb
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit when the limit is off.
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]    grant_onehot_q, grant_onehot_d;
  logic            timeout_q, timeout_d;

  logic            found;
  logic [IDXW-1:0] winner;
  logic [IDXW-1:0] scan_idx;
  int              scan;

  logic            rel_done;
  logic            rel_drop;
  logic            rel_hold;

  // Rotating priority scan: first requester at or after ptr, wrapping past N-1 back to 0.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan     = 0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= N) begin
        scan = scan - N;
      end
      scan_idx = IDXW'(scan);
      if (!found && arb.req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Release causes while an owner holds the grant; only the owner's own request bit matters.
  always_comb begin
    rel_done = arb.done;
    rel_drop = !arb.req[grant_idx_q];
    rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  end

  // Next-state logic: arbitrate in IDLE, hold or release in BUSY.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    grant_valid_d  = grant_valid_q;
    grant_idx_d    = grant_idx_q;
    grant_onehot_d = grant_onehot_q;
    timeout_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_idx_d    = winner;
          grant_onehot_d = N'(1) << winner;
          grant_valid_d  = 1'b1;
          hold_cnt_d     = '0;
          state_d        = ST_BUSY;
        end
      end
      default: begin
        if (rel_done || rel_drop || rel_hold) begin
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
          // Owner just served drops to lowest priority for the next scan.
          ptr_d          = (grant_idx_q == IDXW'(N - 1)) ? '0 : grant_idx_q + 1'b1;
          timeout_d      = rel_hold && !rel_done && !rel_drop;
          state_d        = ST_IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset drops any grant at once without a timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      hold_cnt_q     <= '0;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_onehot_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_onehot_q <= grant_onehot_d;
      timeout_q      <= timeout_d;
    end
  end

  assign arb.grant_valid  = grant_valid_q;
  assign arb.grant_idx    = grant_idx_q;
  assign arb.grant_onehot = grant_onehot_q;
  assign arb.timeout      = timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb/tb_rr_onehot_arbiter.sv - table-driven scoreboard bench for rr_onehot_arbiter
module tb_rr_onehot_arbiter;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic        v;
    logic [3:0]  idx;
    logic        to;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  rr_onehot_arbiter_if #(.N(16), .IDXW(4)) arb_if ();

  rr_onehot_arbiter #(
    .N(16),
    .IDXW(4),
    .MAX_HOLD(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .arb  (arb_if)
  );

  task automatic add_a(input logic [15:0] r, input logic d, input logic v, input int i, input logic t);
    vec_t e;
    e = '{req: r, done: d, v: v, idx: 4'(i), to: t};
    vecs_a.push_back(e);
  endtask

  task automatic add_b(input logic [15:0] r, input logic d, input logic v, input int i, input logic t);
    vec_t e;
    e = '{req: r, done: d, v: v, idx: 4'(i), to: t};
    vecs_b.push_back(e);
  endtask

  task automatic check_out(input string name, input logic ev, input logic [3:0] ei, input logic et);
    logic [15:0] eo;
    eo = ev ? (16'h0001 << ei) : 16'h0000;
    n_vec++;
    if (arb_if.grant_valid !== ev || arb_if.grant_idx !== ei ||
        arb_if.grant_onehot !== eo || arb_if.timeout !== et) begin
      n_err++;
      $display("FAIL %s: got valid=%0b idx=%0d onehot=%h timeout=%0b, want valid=%0b idx=%0d onehot=%h timeout=%0b",
               name, arb_if.grant_valid, arb_if.grant_idx, arb_if.grant_onehot, arb_if.timeout,
               ev, ei, eo, et);
    end
  endtask

  task automatic check_inv(input string name);
    logic [15:0] eo;
    eo = arb_if.grant_valid ? (16'h0001 << arb_if.grant_idx) : 16'h0000;
    n_vec++;
    if (arb_if.grant_onehot !== eo) begin
      n_err++;
      $display("FAIL %s invariant: got onehot=%h, want %h (valid=%0b idx=%0d)",
               name, arb_if.grant_onehot, eo, arb_if.grant_valid, arb_if.grant_idx);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    @(negedge clk);
    arb_if.req  = v.req;
    arb_if.done = v.done;
    exp_q.push_back(v);
    @(posedge clk);
    #2;
    check_inv(name);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check_out(name, e.v, e.idx, e.to);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    arb_if.req  = '0;
    arb_if.done = 1'b0;

    // Before the reset hit: owner 3 granted and holding.
    add_a(16'h0008, 0, 1, 3, 0);
    add_a(16'h0008, 0, 1, 3, 0);

    // After reset: done ignored in IDLE, ptr back at 0.
    add_b(16'h0001, 1, 1, 0, 0);
    add_b(16'hFFFF, 1, 0, 0, 0);
    // Rotation 1..15 then wrap to 0, one grant cycle and one idle cycle each.
    for (int g = 1; g <= 16; g++) begin
      add_b(16'hFFFF, 1, 1, g % 16, 0);
      add_b(16'hFFFF, 1, 0, g % 16, 0);
    end
    // Hold limit: owner 2 for 8 cycles, timeout pulse, then 8.
    for (int k = 0; k < 8; k++) add_b(16'h0104, 0, 1, 2, 0);
    add_b(16'h0104, 0, 0, 2, 1);
    add_b(16'h0104, 0, 1, 8, 0);
    add_b(16'h0104, 1, 0, 8, 0);
    // Single request, then scan starts at 6.
    add_b(16'h0020, 0, 1, 5, 0);
    add_b(16'h0020, 1, 0, 5, 0);
    add_b(16'h0060, 0, 1, 6, 0);
    add_b(16'h0060, 1, 0, 6, 0);
    // Owner drops its request: release without timeout, ptr moves to 8.
    add_b(16'h0080, 0, 1, 7, 0);
    add_b(16'h0080, 0, 1, 7, 0);
    add_b(16'h0000, 0, 0, 7, 0);
    add_b(16'h0180, 0, 1, 8, 0);
    add_b(16'h0180, 1, 0, 8, 0);
    // Wrap past 15.
    add_b(16'h4000, 0, 1, 14, 0);
    add_b(16'h4000, 1, 0, 14, 0);
    add_b(16'h0009, 0, 1, 0, 0);
    add_b(16'h0009, 1, 0, 0, 0);
    add_b(16'h0009, 0, 1, 3, 0);
    add_b(16'h0009, 1, 0, 3, 0);
    // Limit reached together with done: no timeout.
    for (int k = 0; k < 8; k++) add_b(16'h0010, 0, 1, 4, 0);
    add_b(16'h0010, 1, 0, 4, 0);
    // Limit reached together with a drop: no timeout.
    for (int k = 0; k < 8; k++) add_b(16'h0020, 0, 1, 5, 0);
    add_b(16'h0000, 0, 0, 5, 0);
    // done with no requests stays idle; other requests mid-grant do not disturb owner 6.
    add_b(16'h0000, 1, 0, 5, 0);
    add_b(16'h0040, 0, 1, 6, 0);
    add_b(16'h00C0, 0, 1, 6, 0);
    add_b(16'h0040, 1, 0, 6, 0);
    add_b(16'h0080, 0, 1, 7, 0);

    repeat (2) @(negedge clk);
    check_out("reset_state", 0, 4'd0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs_a.size(); i++) apply(vecs_a[i], $sformatf("pre_reset%0d", i));

    // Reset asserted mid-cycle while BUSY: grant must vanish immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("reset_in_busy", 0, 4'd0, 0);
    @(negedge clk);
    arb_if.req = '0;
    @(posedge clk);
    #2;
    check_out("reset_held", 0, 4'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs_b.size(); i++) apply(vecs_b[i], $sformatf("vec%0d", i));

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
